// File: rtl/sdram_cmd_scheduler.sv
// Post-init SDRAM command scheduler: two single-word client ports plus periodic auto-refresh.
// Define SDRAM_SCHED_RR_EN for round-robin read/write arbitration; otherwise writes beat reads.
module sdram_cmd_scheduler #(
    parameter int REF_INTERVAL = 380,
    parameter int T_RCD        = 2,
    parameter int T_RP         = 2,
    parameter int T_RC         = 4,
    parameter int CAS_LAT      = 2,
    parameter int BURST_LEN    = 8
) (
    input  logic        iclk,
    input  logic        ireset,
    input  logic        iinit_fin,
    input  logic        iwr_req,
    input  logic [24:0] iwr_addr,
    input  logic [15:0] iwr_data,
    output logic        owr_ack,
    input  logic        ird_req,
    input  logic [24:0] ird_addr,
    output logic        ord_ack,
    output logic [15:0] ord_data,
    output logic        ord_valid,
    output logic [3:0]  ocmd,
    output logic [12:0] oaddr,
    output logic [1:0]  oba,
    output logic [1:0]  odqm,
    output logic [15:0] odq_out,
    output logic        odq_oe,
    input  logic [15:0] idq_in,
    output logic        obusy,
    output logic [3:0]  odbg_state
);

    localparam logic [3:0] CMD_NOP     = 4'b0111;
    localparam logic [3:0] CMD_ACTIVE  = 4'b0011;
    localparam logic [3:0] CMD_READ    = 4'b0101;
    localparam logic [3:0] CMD_WRITE   = 4'b0100;
    localparam logic [3:0] CMD_REFRESH = 4'b0001;

    localparam int              REF_W    = $clog2(REF_INTERVAL);
    localparam logic [REF_W-1:0] REF_LAST = REF_W'(REF_INTERVAL - 1);

    // RD_WAIT counts down from BURST_LEN+T_RP-1; the first burst word lands CAS_LAT edges after READ.
    localparam logic [7:0] CAP_CNT = 8'(BURST_LEN + T_RP + 1 - CAS_LAT);

    typedef enum logic [3:0] {
        WAIT_INIT = 4'd0,
        IDLE      = 4'd1,
        REF       = 4'd2,
        REF_WAIT  = 4'd3,
        ACT       = 4'd4,
        ACT_WAIT  = 4'd5,
        WR        = 4'd6,
        WR_WAIT   = 4'd7,
        RD        = 4'd8,
        RD_WAIT   = 4'd9
    } state_t;

    state_t           state;
    logic [7:0]       wait_cnt;
    logic [REF_W-1:0] ref_cnt;
    logic             ref_pend;
    logic             ref_wrap;
    logic             ref_take;

    logic             lat_wr;
    logic [1:0]       lat_bank;
    logic [9:0]       lat_col;
    logic [15:0]      lat_data;
    logic [15:0]      cap_data;
    logic             cap_valid;

    logic             grant_wr;
    logic             grant_rd;
    logic             client_grant;
    logic [24:0]      sel_addr;

    // Client handshake: a request is a level held until its ack; the ack is a single-cycle
    // pulse coinciding with the WRITE/READ command, after which the level may drop or stay
    // high to present the next transaction. Requests are only looked at while in IDLE.
    assign client_grant = (state == IDLE) && !ref_pend && (iwr_req || ird_req);

`ifdef SDRAM_SCHED_RR_EN
    logic last_rd;

    always_ff @(posedge iclk) begin
        if (ireset) begin
            last_rd <= 1'b1;
        end else if (client_grant) begin
            last_rd <= grant_rd;
        end
    end

    always_comb begin
        grant_wr = iwr_req && (!ird_req || last_rd);
    end
`else
    always_comb begin
        grant_wr = iwr_req;
    end
`endif

    assign grant_rd   = ird_req && !grant_wr;
    assign sel_addr   = grant_wr ? iwr_addr : ird_addr;
    assign obusy      = (state != IDLE);
    assign odbg_state = state;

    // Refresh timer: free-runs once initialised; a wrap while already pending is absorbed.
    assign ref_wrap = (state != WAIT_INIT) && (ref_cnt == REF_LAST);
    assign ref_take = (state == IDLE) && ref_pend;

    always_ff @(posedge iclk) begin
        if (ireset) begin
            ref_cnt  <= '0;
            ref_pend <= 1'b0;
        end else begin
            if (state != WAIT_INIT) begin
                ref_cnt <= ref_wrap ? '0 : ref_cnt + REF_W'(1);
            end
            if (ref_wrap) begin
                ref_pend <= 1'b1;
            end else if (ref_take) begin
                ref_pend <= 1'b0;
            end
        end
    end

    // Outputs are registered alongside the state: the command on the bus belongs to the
    // state currently held, so each transition loads the next state's command.
    always_ff @(posedge iclk) begin
        if (ireset) begin
            state     <= WAIT_INIT;
            wait_cnt  <= '0;
            ocmd      <= CMD_NOP;
            oaddr     <= '0;
            oba       <= '0;
            odqm      <= 2'b11;
            odq_oe    <= 1'b0;
            odq_out   <= '0;
            owr_ack   <= 1'b0;
            ord_ack   <= 1'b0;
            ord_valid <= 1'b0;
            ord_data  <= '0;
            cap_data  <= '0;
            cap_valid <= 1'b0;
            lat_wr    <= 1'b0;
            lat_bank  <= '0;
            lat_col   <= '0;
            lat_data  <= '0;
        end else begin
            ocmd      <= CMD_NOP;
            oaddr     <= '0;
            oba       <= '0;
            odqm      <= 2'b11;
            odq_oe    <= 1'b0;
            owr_ack   <= 1'b0;
            ord_ack   <= 1'b0;
            cap_valid <= 1'b0;
            ord_valid <= cap_valid;
            if (cap_valid) begin
                ord_data <= cap_data;
            end

            case (state)
                WAIT_INIT: begin
                    if (iinit_fin) begin
                        state <= IDLE;
                    end
                end

                IDLE: begin
                    if (ref_pend) begin
                        state <= REF;
                        ocmd  <= CMD_REFRESH;
                    end else if (client_grant) begin
                        state    <= ACT;
                        ocmd     <= CMD_ACTIVE;
                        oba      <= sel_addr[24:23];
                        oaddr    <= sel_addr[22:10];
                        lat_wr   <= grant_wr;
                        lat_bank <= sel_addr[24:23];
                        lat_col  <= sel_addr[9:0];
                        if (grant_wr) begin
                            lat_data <= iwr_data;
                        end
                    end
                end

                REF: begin
                    state    <= REF_WAIT;
                    wait_cnt <= 8'(T_RC - 1);
                end

                REF_WAIT: begin
                    if (wait_cnt == 8'd0) begin
                        state <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt - 8'd1;
                    end
                end

                ACT: begin
                    state    <= ACT_WAIT;
                    wait_cnt <= 8'(T_RCD - 2);
                end

                ACT_WAIT: begin
                    if (wait_cnt == 8'd0) begin
                        oaddr <= {2'b00, 1'b1, lat_col};
                        oba   <= lat_bank;
                        odqm  <= 2'b00;
                        if (lat_wr) begin
                            state   <= WR;
                            ocmd    <= CMD_WRITE;
                            odq_oe  <= 1'b1;
                            odq_out <= lat_data;
                            owr_ack <= 1'b1;
                        end else begin
                            state   <= RD;
                            ocmd    <= CMD_READ;
                            ord_ack <= 1'b1;
                        end
                    end else begin
                        wait_cnt <= wait_cnt - 8'd1;
                    end
                end

                WR: begin
                    state    <= WR_WAIT;
                    wait_cnt <= 8'(T_RP + 1);
                end

                WR_WAIT: begin
                    if (wait_cnt == 8'd0) begin
                        state <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt - 8'd1;
                    end
                end

                RD: begin
                    state    <= RD_WAIT;
                    wait_cnt <= 8'(BURST_LEN + T_RP - 1);
                    odqm     <= 2'b00;
                end

                RD_WAIT: begin
                    odqm <= (wait_cnt > 8'(T_RP)) ? 2'b00 : 2'b11;
                    if (wait_cnt == CAP_CNT) begin
                        cap_data  <= idq_in;
                        cap_valid <= 1'b1;
                    end
                    if (wait_cnt == 8'd0) begin
                        state <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt - 8'd1;
                    end
                end

                default: begin
                    state <= WAIT_INIT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_cmd_scheduler.sv
// Directed bench for sdram_cmd_scheduler: init, write/read sequencing, refresh timing,
// refresh-vs-client priority, reset mid-read and continuous two-port arbitration.
module tb_sdram_cmd_scheduler;

    localparam logic [3:0] C_NOP = 4'b0111;
    localparam logic [3:0] C_ACT = 4'b0011;
    localparam logic [3:0] C_RD  = 4'b0101;
    localparam logic [3:0] C_WR  = 4'b0100;
    localparam logic [3:0] C_REF = 4'b0001;

    logic        iclk = 1'b0;
    logic        ireset = 1'b1;
    logic        iinit_fin = 1'b0;
    logic        iwr_req = 1'b0;
    logic [24:0] iwr_addr = '0;
    logic [15:0] iwr_data = '0;
    logic        owr_ack;
    logic        ird_req = 1'b0;
    logic [24:0] ird_addr = '0;
    logic        ord_ack;
    logic [15:0] ord_data;
    logic        ord_valid;
    logic [3:0]  ocmd;
    logic [12:0] oaddr;
    logic [1:0]  oba;
    logic [1:0]  odqm;
    logic [15:0] odq_out;
    logic        odq_oe;
    logic [15:0] idq_in = 16'hDEAD;
    logic        obusy;
    logic [3:0]  odbg_state;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int e0 = 0;

    // Hand-computed address vectors: {bank, row, col} and the expected bus fields.
    logic [24:0] addr_t [2]  = '{25'h0A0005, {2'b11, 13'h1ABC, 10'h3FF}};
    logic [1:0]  ba_t [2]    = '{2'd0, 2'd3};
    logic [12:0] row_t [2]   = '{13'h0280, 13'h1ABC};
    logic [12:0] rwa_t [2]   = '{13'h0405, 13'h07FF};
    logic [15:0] wdata_t [2] = '{16'hBEEF, 16'h1357};
    logic [15:0] rdata_t [2] = '{16'hBEEF, 16'h5A5A};

    sdram_cmd_scheduler dut (
        .iclk       (iclk),
        .ireset     (ireset),
        .iinit_fin  (iinit_fin),
        .iwr_req    (iwr_req),
        .iwr_addr   (iwr_addr),
        .iwr_data   (iwr_data),
        .owr_ack    (owr_ack),
        .ird_req    (ird_req),
        .ird_addr   (ird_addr),
        .ord_ack    (ord_ack),
        .ord_data   (ord_data),
        .ord_valid  (ord_valid),
        .ocmd       (ocmd),
        .oaddr      (oaddr),
        .oba        (oba),
        .odqm       (odqm),
        .odq_out    (odq_out),
        .odq_oe     (odq_oe),
        .idq_in     (idq_in),
        .obusy      (obusy),
        .odbg_state (odbg_state)
    );

    always #5 iclk = ~iclk;
    always @(posedge iclk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge iclk);
        #1;
    endtask

    task automatic test_reset();
        ireset = 1'b1;
        iinit_fin = 1'b0;
        repeat (3) tick();
        checks++;
        if ({ocmd, oaddr, oba, odqm, odq_oe, odq_out, ord_data, owr_ack, ord_ack, ord_valid, obusy, odbg_state}
            !== {C_NOP, 13'h0, 2'd0, 2'b11, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0}) begin
            failures++;
            $display("FAIL reset_values: got cmd=%b addr=%h ba=%0d dqm=%b oe=%b dq=%h rdata=%h acks=%b%b%b busy=%b st=%0d want cmd=0111 zeros dqm=11 busy=1 st=0",
                     ocmd, oaddr, oba, odqm, odq_oe, odq_out, ord_data, owr_ack, ord_ack, ord_valid, obusy, odbg_state);
        end
        ireset = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            tick();
            checks++;
            if ({ocmd, obusy, odbg_state} !== {C_NOP, 1'b1, 4'd0}) begin
                failures++;
                $display("FAIL wait_init[%0d]: got cmd=%b busy=%b st=%0d want cmd=0111 busy=1 st=0", c, ocmd, obusy, odbg_state);
            end
        end
        iinit_fin = 1'b1;
        tick();
        e0 = cyc;
        checks++;
        if ({ocmd, obusy, odbg_state} !== {C_NOP, 1'b0, 4'd1}) begin
            failures++;
            $display("FAIL init_to_idle: got cmd=%b busy=%b st=%0d want cmd=0111 busy=0 st=1", ocmd, obusy, odbg_state);
        end
    endtask

    task automatic test_write();
        for (int v = 0; v < 2; v++) begin
            iwr_addr = addr_t[v];
            iwr_data = wdata_t[v];
            iwr_req = 1'b1;
            tick();
            checks++;
            if ({ocmd, oba, oaddr, obusy} !== {C_ACT, ba_t[v], row_t[v], 1'b1}) begin
                failures++;
                $display("FAIL wr_active[%0d]: got cmd=%b ba=%0d addr=%h busy=%b want cmd=%b ba=%0d addr=%h busy=1",
                         v, ocmd, oba, oaddr, obusy, C_ACT, ba_t[v], row_t[v]);
            end
            tick();
            checks++;
            if (ocmd !== C_NOP) begin
                failures++;
                $display("FAIL wr_trcd_nop[%0d]: got cmd=%b want %b", v, ocmd, C_NOP);
            end
            tick();
            checks++;
            if ({ocmd, oba, oaddr, odq_out, odq_oe, odqm, owr_ack} !== {C_WR, ba_t[v], rwa_t[v], wdata_t[v], 1'b1, 2'b00, 1'b1}) begin
                failures++;
                $display("FAIL wr_write[%0d]: got cmd=%b ba=%0d addr=%h dq=%h oe=%b dqm=%b ack=%b want cmd=%b ba=%0d addr=%h dq=%h oe=1 dqm=00 ack=1",
                         v, ocmd, oba, oaddr, odq_out, odq_oe, odqm, owr_ack, C_WR, ba_t[v], rwa_t[v], wdata_t[v]);
            end
            iwr_req = 1'b0;
            tick();
            checks++;
            if ({ocmd, odq_oe, odqm, owr_ack} !== {C_NOP, 1'b0, 2'b11, 1'b0}) begin
                failures++;
                $display("FAIL wr_after[%0d]: got cmd=%b oe=%b dqm=%b ack=%b want cmd=0111 oe=0 dqm=11 ack=0", v, ocmd, odq_oe, odqm, owr_ack);
            end
            repeat (3) tick();
            checks++;
            if (obusy !== 1'b1) begin
                failures++;
                $display("FAIL wr_recovery_busy[%0d]: got %b want 1", v, obusy);
            end
            tick();
            checks++;
            if (obusy !== 1'b0) begin
                failures++;
                $display("FAIL wr_back_idle[%0d]: got busy=%b want 0", v, obusy);
            end
        end
    endtask

    task automatic test_read();
        for (int v = 0; v < 2; v++) begin
            ird_addr = addr_t[v];
            ird_req = 1'b1;
            idq_in = 16'hDEAD;
            tick();
            checks++;
            if ({ocmd, oba, oaddr} !== {C_ACT, ba_t[v], row_t[v]}) begin
                failures++;
                $display("FAIL rd_active[%0d]: got cmd=%b ba=%0d addr=%h want cmd=%b ba=%0d addr=%h", v, ocmd, oba, oaddr, C_ACT, ba_t[v], row_t[v]);
            end
            tick();
            tick();
            checks++;
            if ({ocmd, oba, oaddr, odqm, ord_ack, odq_oe} !== {C_RD, ba_t[v], rwa_t[v], 2'b00, 1'b1, 1'b0}) begin
                failures++;
                $display("FAIL rd_read[%0d]: got cmd=%b ba=%0d addr=%h dqm=%b ack=%b oe=%b want cmd=%b ba=%0d addr=%h dqm=00 ack=1 oe=0",
                         v, ocmd, oba, oaddr, odqm, ord_ack, odq_oe, C_RD, ba_t[v], rwa_t[v]);
            end
            ird_req = 1'b0;
            tick();
            checks++;
            if ({odqm, ord_valid, ord_ack} !== {2'b00, 1'b0, 1'b0}) begin
                failures++;
                $display("FAIL rd_burst_dqm[%0d]: got dqm=%b valid=%b ack=%b want dqm=00 valid=0 ack=0", v, odqm, ord_valid, ord_ack);
            end
            idq_in = rdata_t[v];
            tick();
            checks++;
            if (ord_valid !== 1'b0) begin
                failures++;
                $display("FAIL rd_valid_early[%0d]: got %b want 0", v, ord_valid);
            end
            idq_in = 16'h1234;
            tick();
            checks++;
            if ({ord_valid, ord_data} !== {1'b1, rdata_t[v]}) begin
                failures++;
                $display("FAIL rd_capture[%0d]: got valid=%b data=%h want valid=1 data=%h", v, ord_valid, ord_data, rdata_t[v]);
            end
            idq_in = 16'h4321;
            tick();
            checks++;
            if ({ord_valid, ord_data} !== {1'b0, rdata_t[v]}) begin
                failures++;
                $display("FAIL rd_hold[%0d]: got valid=%b data=%h want valid=0 data=%h", v, ord_valid, ord_data, rdata_t[v]);
            end
            repeat (6) tick();
            checks++;
            if (obusy !== 1'b1) begin
                failures++;
                $display("FAIL rd_recovery_busy[%0d]: got %b want 1", v, obusy);
            end
            tick();
            checks++;
            if ({obusy, odqm} !== {1'b0, 2'b11}) begin
                failures++;
                $display("FAIL rd_back_idle[%0d]: got busy=%b dqm=%b want busy=0 dqm=11", v, obusy, odqm);
            end
            idq_in = 16'hDEAD;
        end
    endtask

    task automatic test_refresh_idle();
        int ref_t [$];
        int exp_t [3];
        exp_t = '{e0 + 381, e0 + 761, e0 + 1141};
        iinit_fin = 1'b0;
        while (cyc < e0 + 1200) begin
            tick();
            if (ocmd === C_REF) ref_t.push_back(cyc);
        end
        checks++;
        if (ref_t.size() !== 3) begin
            failures++;
            $display("FAIL ref_count: got %0d refreshes want 3", ref_t.size());
        end
        for (int i = 0; i < 3; i++) begin
            if (i < ref_t.size()) begin
                checks++;
                if (ref_t[i] !== exp_t[i]) begin
                    failures++;
                    $display("FAIL ref_time[%0d]: got cycle %0d want %0d", i, ref_t[i] - e0, exp_t[i] - e0);
                end
            end
        end
    endtask

    task automatic test_refresh_pending();
        while (cyc < e0 + 1520) tick();
        iwr_addr = addr_t[1];
        iwr_data = 16'hA5C3;
        iwr_req = 1'b1;
        tick();
        checks++;
        if (ocmd !== C_REF) begin
            failures++;
            $display("FAIL refpend_refresh: got cmd=%b want %b", ocmd, C_REF);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (ocmd !== C_NOP) begin
                failures++;
                $display("FAIL refpend_trc_nop[%0d]: got cmd=%b want %b", i, ocmd, C_NOP);
            end
        end
        tick();
        checks++;
        if ({ocmd, oba, oaddr} !== {C_ACT, 2'd3, 13'h1ABC}) begin
            failures++;
            $display("FAIL refpend_active: got cmd=%b ba=%0d addr=%h want cmd=%b ba=3 addr=1abc", ocmd, oba, oaddr, C_ACT);
        end
        tick();
        tick();
        checks++;
        if ({ocmd, odq_out, owr_ack} !== {C_WR, 16'hA5C3, 1'b1}) begin
            failures++;
            $display("FAIL refpend_write: got cmd=%b dq=%h ack=%b want cmd=%b dq=a5c3 ack=1", ocmd, odq_out, owr_ack, C_WR);
        end
        iwr_req = 1'b0;
        for (int i = 0; i < 20 && obusy; i++) tick();
        checks++;
        if (obusy !== 1'b0) begin
            failures++;
            $display("FAIL refpend_idle_timeout: got busy=%b want 0", obusy);
        end
    endtask

    task automatic test_reset_rd_wait();
        ird_addr = addr_t[0];
        ird_req = 1'b1;
        idq_in = 16'hBEEF;
        repeat (3) tick();
        checks++;
        if ({ocmd, ord_ack} !== {C_RD, 1'b1}) begin
            failures++;
            $display("FAIL rst_rd_read: got cmd=%b ack=%b want cmd=%b ack=1", ocmd, ord_ack, C_RD);
        end
        ird_req = 1'b0;
        tick();
        ireset = 1'b1;
        iinit_fin = 1'b0;
        tick();
        checks++;
        if ({ocmd, odqm, odbg_state, obusy, ord_valid, ord_ack, owr_ack, odq_oe, ord_data}
            !== {C_NOP, 2'b11, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0}) begin
            failures++;
            $display("FAIL rst_rd_state: got cmd=%b dqm=%b st=%0d busy=%b valid=%b acks=%b%b oe=%b data=%h want cmd=0111 dqm=11 st=0 busy=1 valid=0 acks=00 oe=0 data=0000",
                     ocmd, odqm, odbg_state, obusy, ord_valid, ord_ack, owr_ack, odq_oe, ord_data);
        end
        ireset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if ({ord_valid, obusy, ocmd} !== {1'b0, 1'b1, C_NOP}) begin
                failures++;
                $display("FAIL rst_rd_quiet[%0d]: got valid=%b busy=%b cmd=%b want valid=0 busy=1 cmd=0111", i, ord_valid, obusy, ocmd);
            end
        end
        idq_in = 16'hDEAD;
        iinit_fin = 1'b1;
        tick();
        checks++;
        if (obusy !== 1'b0) begin
            failures++;
            $display("FAIL rst_rd_reinit: got busy=%b want 0", obusy);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] seq [4];
        int t [4];
        logic [3:0] exp_seq [4];
        int exp_gap [3];
        int n;
`ifdef SDRAM_SCHED_RR_EN
        exp_seq = '{C_WR, C_RD, C_WR, C_RD};
        exp_gap = '{8, 14, 8};
`else
        exp_seq = '{C_WR, C_WR, C_WR, C_WR};
        exp_gap = '{8, 8, 8};
`endif
        n = 0;
        iwr_addr = addr_t[0];
        iwr_data = 16'h0F0F;
        ird_addr = addr_t[1];
        iwr_req = 1'b1;
        ird_req = 1'b1;
        for (int i = 0; i < 300 && (iwr_req || ird_req); i++) begin
            tick();
            if (ocmd === C_WR || ocmd === C_RD) begin
                if (n < 4) begin
                    seq[n] = ocmd;
                    t[n] = cyc;
                    n++;
                end
                if (n >= 4) begin
                    if (owr_ack) iwr_req = 1'b0;
                    if (ord_ack) ird_req = 1'b0;
                end
            end
        end
        checks++;
        if ({iwr_req, ird_req} !== 2'b00 || n != 4) begin
            failures++;
            $display("FAIL b2b_timeout: got %0d commands, pending reqs=%b%b want 4 commands and both acked", n, iwr_req, ird_req);
            iwr_req = 1'b0;
            ird_req = 1'b0;
        end else begin
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (seq[k] !== exp_seq[k]) begin
                    failures++;
                    $display("FAIL b2b_order[%0d]: got cmd=%b want %b", k, seq[k], exp_seq[k]);
                end
            end
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (t[k+1] - t[k] !== exp_gap[k]) begin
                    failures++;
                    $display("FAIL b2b_gap[%0d]: got %0d cycles want %0d", k, t[k+1] - t[k], exp_gap[k]);
                end
            end
        end
        repeat (20) tick();
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_refresh_idle();
        test_refresh_pending();
        test_reset_rd_wait();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
